// File: rtl/pb_debounce.sv
// pb_debounce: per-channel pin synchroniser, debouncer, press/release strobes and 2-bit press counter.
// Defining LONG_PRESS_EN adds a one-shot long-press strobe on PB_LONG; otherwise PB_LONG is tied low.
module pb_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic                 OSC_FPGA,
    input  logic                 RST_N,
    input  logic [WIDTH-1:0]     PB_IN,
    output logic [WIDTH-1:0]     PB_LEVEL,
    output logic [WIDTH-1:0]     PB_PRESS,
    output logic [WIDTH-1:0]     PB_RELEASE,
    output logic [2*WIDTH-1:0]   PRESS_COUNT,
    output logic [WIDTH-1:0]     PB_LONG
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1, sync2, s;

    // Reset to the inactive pin level so s reads "released" straight out of reset
    always_ff @(posedge OSC_FPGA or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= {WIDTH{ACTIVE_LOW}};
            sync2 <= {WIDTH{ACTIVE_LOW}};
        end else begin
            sync1 <= PB_IN;
            sync2 <= sync1;
        end
    end

    assign s = sync2 ^ {WIDTH{ACTIVE_LOW}};

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          level, press, release_s;
        logic [1:0]    pc;
        always_ff @(posedge OSC_FPGA or negedge RST_N) begin
            if (!RST_N) begin
                cnt       <= '0;
                level     <= 1'b0;
                press     <= 1'b0;
                release_s <= 1'b0;
                pc        <= 2'd0;
            end else begin
                press     <= 1'b0;
                release_s <= 1'b0;
                if (s[i] == level) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    cnt       <= '0;
                    level     <= s[i];
                    press     <= s[i];
                    release_s <= !s[i];
                    if (s[i])
                        pc <= pc + 2'd1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
        assign PB_LEVEL[i]           = level;
        assign PB_PRESS[i]           = press;
        assign PB_RELEASE[i]         = release_s;
        assign PRESS_COUNT[2*i +: 2] = pc;
`ifdef LONG_PRESS_EN
        localparam int HW = $clog2(LONG_CYCLES + 1);
        localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
        logic [HW-1:0] hold;
        logic          lng;
        // Hold counter saturates at HOLD_MAX so only one strobe fires per press
        always_ff @(posedge OSC_FPGA or negedge RST_N) begin
            if (!RST_N) begin
                hold <= '0;
                lng  <= 1'b0;
            end else begin
                lng  <= level && (hold == HOLD_MAX - 1'b1);
                hold <= !level ? '0 : (hold == HOLD_MAX ? hold : hold + 1'b1);
            end
        end
        assign PB_LONG[i] = lng;
`else
        assign PB_LONG[i] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_pb_debounce.sv
// tb_pb_debounce: random and directed stimulus on an active-high and an active-low instance,
// both checked every cycle against a sliding-window reference model.
module tb_pb_debounce;
    localparam int W = 2;
    localparam int D = 4;
    localparam int L = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] pin = '1;
    logic [W-1:0] pin_n;
    logic [W-1:0] lv_h, pr_h, rl_h, lg_h, lv_l, pr_l, rl_l, lg_l;
    logic [2*W-1:0] pc_h, pc_l;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    assign pin_n = ~pin;

    pb_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0), .LONG_CYCLES(L)) u_hi (
        .OSC_FPGA(clk), .RST_N(rst_n), .PB_IN(pin), .PB_LEVEL(lv_h), .PB_PRESS(pr_h),
        .PB_RELEASE(rl_h), .PRESS_COUNT(pc_h), .PB_LONG(lg_h));

    pb_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1), .LONG_CYCLES(L)) u_lo (
        .OSC_FPGA(clk), .RST_N(rst_n), .PB_IN(pin_n), .PB_LEVEL(lv_l), .PB_PRESS(pr_l),
        .PB_RELEASE(rl_l), .PRESS_COUNT(pc_l), .PB_LONG(lg_l));

    // Reference model: pressed-value history delayed two cycles, plus a window of samples since the last change
    logic [W-1:0] q[$];
    bit           sh[W][$];
    logic [W-1:0] m_level, m_press, m_rel, m_long;
    logic [1:0]   m_cnt[W];
    int           rise_k[W];
    int           k;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q = '{'0, '0};
        for (int c = 0; c < W; c++) begin
            sh[c].delete();
            m_cnt[c] = 2'd0;
            rise_k[c] = 0;
        end
        m_level = '0;
        m_press = '0;
        m_rel = '0;
        m_long = '0;
        k = 0;
    endtask

    task automatic model_edge();
        logic [W-1:0] s;
        bit all_diff;
        s = q[0];
        q.push_back(pin);
        void'(q.pop_front());
        m_press = '0;
        m_rel = '0;
        m_long = '0;
        for (int c = 0; c < W; c++) begin
`ifdef LONG_PRESS_EN
            if (m_level[c] && (k - rise_k[c] == L)) m_long[c] = 1'b1;
`endif
            sh[c].push_back(s[c]);
            if (sh[c].size() > D) void'(sh[c].pop_front());
            all_diff = (sh[c].size() == D);
            for (int j = 0; j < sh[c].size(); j++)
                if (sh[c][j] == m_level[c]) all_diff = 1'b0;
            if (all_diff) begin
                m_level[c] = ~m_level[c];
                sh[c].delete();
                if (m_level[c]) begin
                    m_press[c] = 1'b1;
                    m_cnt[c] = 2'((m_cnt[c] + 1) % 4);
                    rise_k[c] = k;
                end else begin
                    m_rel[c] = 1'b1;
                end
            end
        end
        k++;
    endtask

    task automatic compare_all();
        check("hi.level", 4'(lv_h), 4'(m_level));
        check("hi.press", 4'(pr_h), 4'(m_press));
        check("hi.release", 4'(rl_h), 4'(m_rel));
        check("hi.count", pc_h, {m_cnt[1], m_cnt[0]});
        check("hi.long", 4'(lg_h), 4'(m_long));
        check("hi.excl", 4'(pr_h & rl_h), 4'd0);
        check("lo.level", 4'(lv_l), 4'(m_level));
        check("lo.press", 4'(pr_l), 4'(m_press));
        check("lo.release", 4'(rl_l), 4'(m_rel));
        check("lo.count", pc_l, {m_cnt[1], m_cnt[0]});
        check("lo.long", 4'(lg_l), 4'(m_long));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".level"}, 4'(lv_h | lv_l), 4'd0);
        check({tag, ".strobe"}, 4'(pr_h | rl_h | pr_l | rl_l), 4'd0);
        check({tag, ".count"}, pc_h | pc_l, 4'd0);
        check({tag, ".long"}, 4'(lg_h | lg_l), 4'd0);
    endtask

    task automatic cyc(input logic [W-1:0] p);
        pin = p;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        logic [W-1:0] rp;
        int run[W];
        int w;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(2'b11);
            if (i == 5) begin
                check("first.press", 4'(pr_h), 4'b0011);
                check("first.count", pc_h, 4'b0101);
                check("first.lo_level", 4'(lv_l), 4'b0011);
            end
        end
        repeat (8) cyc(2'b00);
        for (int g = 1; g <= 3; g++) begin
            repeat (g) cyc(2'b01);
            repeat (4) cyc(2'b00);
        end
        check("glitch.count", pc_h, 4'b0101);
        repeat (6) cyc(2'b01);
        repeat (6) cyc(2'b00);
        for (int n = 0; n < 4; n++) begin
            repeat (6) cyc(2'b10);
            repeat (6) cyc(2'b00);
        end
        repeat (30) cyc(2'b01);
        repeat (8) cyc(2'b00);
        rp = '0;
        run = '{1, 1};
        repeat (400) begin
            for (int c = 0; c < W; c++) begin
                run[c]--;
                if (run[c] == 0) begin
                    rp[c] = ~rp[c];
                    run[c] = $urandom_range(1, 14);
                end
            end
            cyc(rp);
        end
        w = 0;
        while (!lv_h[0] && w < 20) begin
            cyc(2'b01);
            w++;
        end
        check("mid.pressed", 4'(lv_h[0]), 4'd1);
        rst_n = 1'b0;
        #1;
        check_zero("mid.async");
        repeat (2) @(posedge clk);
        #1;
        check_zero("mid.hold");
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(2'b01);
            if (i == 5) check("mid.repress", 4'(pr_h), 4'b0001);
        end
        rp = pin;
        repeat (300) begin
            for (int c = 0; c < W; c++) begin
                run[c]--;
                if (run[c] <= 0) begin
                    rp[c] = ~rp[c];
                    run[c] = $urandom_range(1, 14);
                end
            end
            cyc(rp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
